// File: rtl/bird_ctrl.sv
// bird_ctrl: IDLE/PLAY/DEAD game FSM with per-tick bird physics, pipe collision and scoring.
// Latency: flap press reaches the pending latch 3 cycles after the pin rises; BirdY/Score/Lost/Playing are registered and change the cycle after a tick.
// Backpressure: none. Presses between two ticks collapse into one flap, and DEAD ignores everything except a press.
//
// Ports:
//   Clk     - system clock
//   Reset   - synchronous, active-high reset
//   Flap    - raw asynchronous flap button
//   PipeX   - pipe left edge (px)
//   PipeY   - pipe gap centre (px)
//   BirdY   - bird top edge (px)
//   Score   - pipes passed, binary, saturates at 9999
//   Lost    - high while in DEAD
//   Playing - high while in PLAY
//
// Optional feature: define BIRD_DEBOUNCE_EN to debounce the synchronised button.
// The level must then hold stable for DEBOUNCE_CYCLES cycles before a press is seen.
module bird_ctrl #(
  parameter int TICK_DIV        = 1666667,
  parameter int START_Y         = 240,
  parameter int FLOOR_Y         = 470,
  parameter int BIRD_X          = 160,
  parameter int BIRD_W          = 16,
  parameter int BIRD_H          = 16,
  parameter int PIPE_W          = 40,
  parameter int GAP_HALF        = 60,
  parameter int GRAVITY         = 1,
  parameter int FLAP_V          = 8,
  parameter int MAX_FALL        = 10,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Flap,
  input  logic [9:0]  PipeX,
  input  logic [9:0]  PipeY,
  output logic [9:0]  BirdY,
  output logic [15:0] Score,
  output logic        Lost,
  output logic        Playing
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Physics is done signed in 12 bits so an upward move past the top shows up as negative.
  localparam logic signed [11:0] GRAV_S   = 12'(GRAVITY);
  localparam logic signed [11:0] FLAP_S   = 12'(FLAP_V);
  localparam logic signed [11:0] MAXF_S   = 12'(MAX_FALL);
  localparam logic signed [11:0] BIRD_H_S = 12'(BIRD_H);
  localparam logic signed [11:0] FLOOR_S  = 12'(FLOOR_Y);
  localparam logic [9:0]         REST_Y   = 10'(FLOOR_Y - BIRD_H);
  localparam logic [9:0]         START_YV = 10'(START_Y);

  // Collision/score geometry is unsigned 11-bit so PipeX+PIPE_W and PipeY+GAP_HALF cannot wrap.
  localparam logic [10:0] BX_U  = 11'(BIRD_X);
  localparam logic [10:0] BXW_U = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] PW_U  = 11'(PIPE_W);
  localparam logic [10:0] GH_U  = 11'(GAP_HALF);
  localparam logic [10:0] BH_U  = 11'(BIRD_H);

  localparam logic [15:0] SCORE_MAX = 16'd9999;

  // ---------------------------------------------------------------- flap path
  logic flap_s1;
  logic flap_s2;
  logic flap_lvl;
  logic flap_prev;
  logic press;
  logic flap_pend;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flap_s1 <= 1'b0;
      flap_s2 <= 1'b0;
    end else begin
      flap_s1 <= Flap;
      flap_s2 <= flap_s1;
    end
  end

`ifdef BIRD_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DW-1:0] db_cnt;
  logic          db_lvl;

  // The counter restarts whenever the input returns to the accepted level, so only
  // an uninterrupted run of DEBOUNCE_CYCLES differing samples flips db_lvl.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (flap_s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= flap_s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign flap_lvl = db_lvl;
`else
  assign flap_lvl = flap_s2;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      flap_prev <= 1'b0;
    end else begin
      flap_prev <= flap_lvl;
    end
  end

  assign press = flap_lvl & ~flap_prev;

  // ---------------------------------------------------------------- tick
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A press on the tick cycle itself is kept for the following tick, since the
  // tick only consumes what was already latched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flap_pend <= 1'b0;
    end else begin
      flap_pend <= press | (flap_pend & ~tick);
    end
  end

  // ---------------------------------------------------------------- physics
  state_t             state;
  state_t             state_n;
  logic signed [11:0] vel_q;
  logic signed [11:0] vel_n;
  logic [9:0]         y_n;
  logic [15:0]        score_n;
  logic               scored;
  logic               scored_n;

  logic signed [11:0] vel_inc;
  logic signed [11:0] vel_new;
  logic signed [11:0] y_next;
  logic               ceil_hit;
  logic               floor_hit;
  logic [9:0]         y_new;

  always_comb begin
    vel_inc   = vel_q + GRAV_S;
    vel_new   = flap_pend ? -FLAP_S : ((vel_inc > MAXF_S) ? MAXF_S : vel_inc);
    y_next    = $signed({2'b00, BirdY}) + vel_new;
    ceil_hit  = (y_next < 12'sd0);
    floor_hit = ((y_next + BIRD_H_S) >= FLOOR_S);
    if (ceil_hit) begin
      y_new = 10'd0;
    end else if (floor_hit) begin
      y_new = REST_Y;
    end else begin
      y_new = y_next[9:0];
    end
  end

  // ---------------------------------------------------------------- collision / pass
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] yn;
  logic [10:0] gap_top;
  logic [10:0] gap_bot;
  logic        h_overlap;
  logic        outside_gap;
  logic        collide;
  logic        pass;

  always_comb begin
    px          = {1'b0, PipeX};
    py          = {1'b0, PipeY};
    yn          = {1'b0, y_new};
    gap_top     = (py >= GH_U) ? (py - GH_U) : 11'd0;
    gap_bot     = py + GH_U;
    h_overlap   = (px < BXW_U) && ((px + PW_U) > BX_U);
    outside_gap = (yn < gap_top) || ((yn + BH_U) > gap_bot);
    collide     = h_overlap && outside_gap;
    pass        = ((px + PW_U) < BX_U);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      BirdY  <= START_YV;
      vel_q  <= '0;
      Score  <= '0;
      scored <= 1'b0;
    end else begin
      state  <= state_n;
      BirdY  <= y_n;
      vel_q  <= vel_n;
      Score  <= score_n;
      scored <= scored_n;
    end
  end

  always_comb begin
    state_n  = state;
    y_n      = BirdY;
    vel_n    = vel_q;
    score_n  = Score;
    scored_n = scored;
    unique case (state)
      S_IDLE: begin
        y_n      = START_YV;
        vel_n    = '0;
        score_n  = '0;
        scored_n = 1'b0;
        if (press) begin
          state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          y_n   = y_new;
          vel_n = ceil_hit ? 12'sd0 : vel_new;
          // Collision beats a pass on the same tick; the flag is re-armed only
          // once the pipe has wrapped back to the right of the bird.
          if (pass) begin
            if (!scored && !collide) begin
              score_n  = (Score == SCORE_MAX) ? Score : Score + 16'd1;
              scored_n = 1'b1;
            end
          end else begin
            scored_n = 1'b0;
          end
          if (floor_hit || collide) begin
            state_n = S_DEAD;
          end
        end
      end
      S_DEAD: begin
        if (press) begin
          state_n  = S_IDLE;
          y_n      = START_YV;
          vel_n    = '0;
          score_n  = '0;
          scored_n = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign Lost    = (state == S_DEAD);
  assign Playing = (state == S_PLAY);

endmodule

// File: tb/tb_bird_ctrl.sv
// tb_bird_ctrl: randomized and directed stimulus for bird_ctrl against a behavioural game model.
// Latency: the model is stepped on every clock edge and outputs are compared 1 time unit later.
// Backpressure: n/a.
module tb_bird_ctrl;

  localparam int TICK = 4;
  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DEAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flap = 1'b0;
  logic [9:0]  pipe_x = 10'd600;
  logic [9:0]  pipe_y = 10'd240;
  logic [9:0]  bird_y;
  logic [15:0] score;
  logic        lost;
  logic        playing;

  bird_ctrl #(.TICK_DIV(TICK)) dut (
    .Clk    (clk),
    .Reset  (rst),
    .Flap   (flap),
    .PipeX  (pipe_x),
    .PipeY  (pipe_y),
    .BirdY  (bird_y),
    .Score  (score),
    .Lost   (lost),
    .Playing(playing)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state: game rules applied in plain integers.
  int m_state = M_IDLE;
  int m_y = 240;
  int m_vel = 0;
  int m_score = 0;
  bit m_scored = 0;
  bit m_pend = 0;
  int m_cnt = 0;
  bit m_ticked = 0;
  bit fh[4];   // fh[0] = Flap sampled at this edge, fh[k] = k edges earlier

  task automatic model_edge();
    bit press;
    bit tick;
    int v;
    int ny;
    int gt;
    bit dead;
    bit coll;
    bit pass;
    m_ticked = 0;
    if (rst) begin
      m_state = M_IDLE; m_y = 240; m_vel = 0; m_score = 0;
      m_scored = 0; m_pend = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) fh[i] = 0;
      return;
    end
    fh[3] = fh[2]; fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = flap;
    // Two synchroniser stages plus the edge register.
    press = fh[2] && !fh[3];
    tick  = (m_cnt == TICK - 1);
    m_ticked = tick;
    case (m_state)
      M_IDLE: begin
        m_y = 240; m_vel = 0; m_score = 0; m_scored = 0;
        if (press) m_state = M_PLAY;
      end
      M_PLAY: begin
        if (tick) begin
          v = m_pend ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
          ny = m_y + v;
          dead = 0;
          if (ny < 0) begin
            ny = 0; v = 0;
          end else if (ny + 16 >= 470) begin
            ny = 454; dead = 1;
          end
          gt   = (pipe_y >= 60) ? pipe_y - 60 : 0;
          coll = (pipe_x < 176) && (pipe_x + 40 > 160) &&
                 ((ny < gt) || (ny + 16 > pipe_y + 60));
          pass = (pipe_x + 40 < 160);
          if (pass) begin
            if (!m_scored && !coll) begin
              m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
              m_scored = 1;
            end
          end else begin
            m_scored = 0;
          end
          m_y = ny; m_vel = v;
          if (dead || coll) m_state = M_DEAD;
        end
      end
      default: begin
        if (press) begin
          m_state = M_IDLE; m_y = 240; m_vel = 0; m_score = 0; m_scored = 0;
        end
      end
    endcase
    m_pend = press || (m_pend && !tick);
    m_cnt  = tick ? 0 : m_cnt + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_eq("birdy", bird_y, m_y);
    chk_eq("score", score, m_score);
    chk_eq("lost", lost, (m_state == M_DEAD));
    chk_eq("playing", playing, (m_state == M_PLAY));
  endtask

  task automatic press_btn();
    flap = 1'b1;
    step();
    step();
    flap = 1'b0;
    step();
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    step();
    while (!m_ticked && k < 2 * TICK) begin
      step();
      k++;
    end
    if (!m_ticked) chk_eq("tick_timeout", m_ticked, 1);
  endtask

  // Flap whenever the bird has sunk to 240; keeps it within 204..240.
  task automatic hover_flap();
    if (m_y >= 240) begin
      flap = 1'b1;
      step();
      step();
      flap = 1'b0;
    end
  endtask

  initial begin
    int k;
    int hit;
    bit done;

    // Reset and idle.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    chk_eq("idle_birdy", bird_y, 240);
    chk_eq("idle_score", score, 0);
    chk_eq("idle_lost", lost, 0);
    chk_eq("idle_playing", playing, 0);

    // One press, pipe far away: flap, rise, then fall to the floor.
    pipe_x = 10'd600;
    pipe_y = 10'd240;
    press_btn();
    chk_eq("press_to_play", playing, 1);
    k = 0;
    while (bird_y == 10'd240 && k < 16) begin
      step();
      k++;
    end
    chk_eq("first_tick_y", bird_y, 232);
    repeat (TICK) step();
    chk_eq("tick2_y", bird_y, 225);
    repeat (TICK) step();
    chk_eq("tick3_y", bird_y, 219);
    repeat (TICK) step();
    chk_eq("tick4_y", bird_y, 214);
    k = 0;
    while (!lost && k < 800) begin
      step();
      k++;
    end
    chk_eq("fall_lost", lost, 1);
    chk_eq("floor_y", bird_y, 454);
    repeat (100) step();
    chk_eq("frozen_y", bird_y, 454);
    chk_eq("frozen_lost", lost, 1);

    // Press in DEAD returns to IDLE.
    press_btn();
    chk_eq("dead_idle_playing", playing, 0);
    chk_eq("dead_idle_lost", lost, 0);
    chk_eq("dead_idle_y", bird_y, 240);

    // Hover through an open gap: score goes to 1 once PipeX+40 < 160.
    pipe_y = 10'd240;
    pipe_x = 10'd200;
    press_btn();
    chk_eq("sweep_play", playing, 1);
    for (int p = 199; p >= 100; p--) begin
      wait_tick();
      chk_eq("sweep_score_edge", score, (pipe_x < 10'd120) ? 1 : 0);
      pipe_x = 10'(p);
      hover_flap();
    end
    wait_tick();
    hover_flap();
    chk_eq("sweep_lost", lost, 0);
    chk_eq("sweep_score", score, 1);
    pipe_x = 10'd600;
    repeat (3) begin
      wait_tick();
      hover_flap();
    end
    chk_eq("wrap_score", score, 1);
    chk_eq("wrap_playing", playing, 1);

    // Same sweep with the gap far below: dies at the first overlapping tick.
    pipe_y = 10'd400;
    hit = -1;
    done = 0;
    for (int p = 200; p >= 100; p--) begin
      if (!done) begin
        wait_tick();
        if (lost) begin
          hit = pipe_x;
          done = 1;
        end else begin
          pipe_x = 10'(p);
          hover_flap();
        end
      end
    end
    chk_eq("hit_px", hit, 175);
    chk_eq("hit_lost", lost, 1);
    chk_eq("hit_score", score, 1);

    // DEAD -> IDLE clears the score.
    press_btn();
    chk_eq("restart_score", score, 0);
    chk_eq("restart_y", bird_y, 240);
    chk_eq("restart_lost", lost, 0);

    // Reset in the middle of a game.
    pipe_x = 10'd600;
    press_btn();
    repeat (10) step();
    chk_eq("pre_rst_playing", playing, 1);
    rst = 1'b1;
    step();
    chk_eq("rst_y", bird_y, 240);
    chk_eq("rst_score", score, 0);
    chk_eq("rst_lost", lost, 0);
    chk_eq("rst_playing", playing, 0);
    rst = 1'b0;

    // Randomized play against the model.
    pipe_x = 10'd400;
    pipe_y = 10'd240;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) flap = ~flap;
      if ((c % TICK) == 0) begin
        if (pipe_x < 10'd8) begin
          pipe_x = 10'd600;
          pipe_y = 10'($urandom_range(40, 440));
        end else begin
          pipe_x = pipe_x - 10'($urandom_range(0, 7));
        end
      end
      if ($urandom_range(0, 60) == 0) pipe_x = 10'($urandom_range(0, 1023));
      rst = ($urandom_range(0, 700) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
